ssd_scan_decoder: RTL and testbench

//  Receive side of the 8-digit multiplexed seven-segment scan bus (active-low anodes, active-low cathodes).

---
 rtl/ssd_pkg.sv | 50 +++++
 rtl/ssd_cathode_decode.sv | 39 +++
 rtl/ssd_scan_decoder.sv | 149 ++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared symbol codes and cathode patterns for the seven-segment scan bus.
// Cathodes are active-low, segments a..g on bits 6..0.
package ssd_pkg;

  localparam int NUM_DIGITS_DEF = 8;

  localparam logic [4:0] SYM_0       = 5'h00;
  localparam logic [4:0] SYM_1       = 5'h01;
  localparam logic [4:0] SYM_2       = 5'h02;
  localparam logic [4:0] SYM_3       = 5'h03;
  localparam logic [4:0] SYM_4       = 5'h04;
  localparam logic [4:0] SYM_5       = 5'h05;
  localparam logic [4:0] SYM_6       = 5'h06;
  localparam logic [4:0] SYM_7       = 5'h07;
  localparam logic [4:0] SYM_8       = 5'h08;
  localparam logic [4:0] SYM_9       = 5'h09;
  localparam logic [4:0] SYM_A       = 5'h0A;
  localparam logic [4:0] SYM_B       = 5'h0B;
  localparam logic [4:0] SYM_C       = 5'h0C;
  localparam logic [4:0] SYM_D       = 5'h0D;
  localparam logic [4:0] SYM_E       = 5'h0E;
  localparam logic [4:0] SYM_F       = 5'h0F;
  localparam logic [4:0] SYM_I       = 5'h11;
  localparam logic [4:0] SYM_U       = 5'h12;
  localparam logic [4:0] SYM_L       = 5'h13;
  localparam logic [4:0] SYM_BLANK   = 5'h14;
  localparam logic [4:0] SYM_UNKNOWN = 5'h1F;

  localparam logic [6:0] CA_0     = 7'b0000001;
  localparam logic [6:0] CA_1     = 7'b1001111;
  localparam logic [6:0] CA_2     = 7'b0010010;
  localparam logic [6:0] CA_3     = 7'b0000110;
  localparam logic [6:0] CA_4     = 7'b1001100;
  localparam logic [6:0] CA_5     = 7'b0100100;
  localparam logic [6:0] CA_6     = 7'b0100000;
  localparam logic [6:0] CA_7     = 7'b0001111;
  localparam logic [6:0] CA_8     = 7'b0000000;
  localparam logic [6:0] CA_9     = 7'b0000100;
  localparam logic [6:0] CA_A     = 7'b0001000;
  localparam logic [6:0] CA_B     = 7'b1100000;
  localparam logic [6:0] CA_C     = 7'b0110001;
  localparam logic [6:0] CA_D     = 7'b1000010;
  localparam logic [6:0] CA_E     = 7'b0110000;
  localparam logic [6:0] CA_F     = 7'b0111000;
  localparam logic [6:0] CA_I     = 7'b1111001;
  localparam logic [6:0] CA_U     = 7'b1000001;
  localparam logic [6:0] CA_L     = 7'b1110001;
  localparam logic [6:0] CA_BLANK = 7'b1111111;

endpackage

// File: rtl/ssd_cathode_decode.sv
// Combinational cathode-pattern to symbol-code lookup; known=0 for patterns
// outside the table, in which case code is SYM_UNKNOWN.
module ssd_cathode_decode
  import ssd_pkg::*;
(
  input  logic [6:0] ca,
  output logic [4:0] code,
  output logic       known
);

  always_comb begin
    code  = SYM_UNKNOWN;
    known = 1'b1;
    case (ca)
      CA_0:     code = SYM_0;
      CA_1:     code = SYM_1;
      CA_2:     code = SYM_2;
      CA_3:     code = SYM_3;
      CA_4:     code = SYM_4;
      CA_5:     code = SYM_5;
      CA_6:     code = SYM_6;
      CA_7:     code = SYM_7;
      CA_8:     code = SYM_8;
      CA_9:     code = SYM_9;
      CA_A:     code = SYM_A;
      CA_B:     code = SYM_B;
      CA_C:     code = SYM_C;
      CA_D:     code = SYM_D;
      CA_E:     code = SYM_E;
      CA_F:     code = SYM_F;
      CA_I:     code = SYM_I;
      CA_U:     code = SYM_U;
      CA_L:     code = SYM_L;
      CA_BLANK: code = SYM_BLANK;
      default:  known = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Receive-side monitor for the multiplexed seven-segment scan bus: synchronises,
// waits for the bus to settle, decodes each lit digit and tracks frame completion.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = NUM_DIGITS_DEF,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   anode_in,
  input  logic [6:0]              cathode_in,
  output logic [5*NUM_DIGITS-1:0] digit_codes,
  output logic [NUM_DIGITS-1:0]   digit_seen,
  output logic                    frame_valid,
  output logic [7:0]              frame_count,
  output logic                    decode_err,
  output logic                    anode_err
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0] an_sync_q [SYNC_STAGES];
  logic [NUM_DIGITS-1:0] an_sync_d [SYNC_STAGES];
  logic [6:0]            ca_sync_q [SYNC_STAGES];
  logic [6:0]            ca_sync_d [SYNC_STAGES];
  logic [CW-1:0]         settle_q, settle_d;
  logic [4:0]            codes_q [NUM_DIGITS];
  logic [4:0]            codes_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen_q, seen_d, seen_set;
  logic [7:0]            count_q, count_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  decode_err_q, decode_err_d;
  logic                  anode_err_q, anode_err_d;

  logic [NUM_DIGITS-1:0] an, an_next, low;
  logic [6:0]            ca, ca_next;
  logic                  changed, sample, multi_low;
  logic [IW-1:0]         idx;
  logic [4:0]            dec_code;
  logic                  dec_known;

  ssd_cathode_decode u_decode (
    .ca    (ca),
    .code  (dec_code),
    .known (dec_known)
  );

  always_comb begin
    an_sync_d[0] = anode_in;
    ca_sync_d[0] = cathode_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      an_sync_d[i] = an_sync_q[i-1];
      ca_sync_d[i] = ca_sync_q[i-1];
    end
  end

  assign an      = an_sync_q[SYNC_STAGES-1];
  assign ca      = ca_sync_q[SYNC_STAGES-1];
  assign an_next = an_sync_q[SYNC_STAGES-2];
  assign ca_next = ca_sync_q[SYNC_STAGES-2];

  // Looking one stage ahead lets the counter read 0 on the very cycle an/ca
  // take a new value, so the sample lands SYNC_STAGES+SETTLE_CYCLES edges out.
  always_comb begin
    changed  = (an_next != an) || (ca_next != ca);
    sample   = !changed && (settle_q == CW'(SETTLE_CYCLES - 1));
    settle_d = settle_q;
    if (changed)
      settle_d = '0;
    else if (settle_q != CW'(SETTLE_CYCLES))
      settle_d = settle_q + 1'b1;
  end

  always_comb begin
    low       = ~an;
    multi_low = (low & (low - 1'b1)) != '0;
    idx       = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (low[k]) idx = IW'(k);
  end

  always_comb begin
    codes_d       = codes_q;
    seen_d        = seen_q;
    seen_set      = seen_q;
    count_d       = count_q;
    frame_valid_d = 1'b0;
    decode_err_d  = 1'b0;
    anode_err_d   = 1'b0;
    if (sample && (low != '0)) begin
      if (multi_low) begin
        anode_err_d = 1'b1;
      end else begin
        codes_d[idx]  = dec_code;
        decode_err_d  = !dec_known;
        seen_set[idx] = 1'b1;
        if (&seen_set) begin
          seen_d        = '0;
          frame_valid_d = 1'b1;
          count_d       = count_q + 8'd1;
        end else begin
          seen_d = seen_set;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        an_sync_q[i] <= '1;
        ca_sync_q[i] <= '1;
      end
      for (int k = 0; k < NUM_DIGITS; k++)
        codes_q[k] <= SYM_BLANK;
      settle_q      <= '0;
      seen_q        <= '0;
      count_q       <= '0;
      frame_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      an_sync_q     <= an_sync_d;
      ca_sync_q     <= ca_sync_d;
      codes_q       <= codes_d;
      settle_q      <= settle_d;
      seen_q        <= seen_d;
      count_q       <= count_d;
      frame_valid_q <= frame_valid_d;
      decode_err_q  <= decode_err_d;
      anode_err_q   <= anode_err_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++)
      digit_codes[5*k +: 5] = codes_q[k];
  end

  assign digit_seen  = seen_q;
  assign frame_count = count_q;
  assign frame_valid = frame_valid_q;
  assign decode_err  = decode_err_q;
  assign anode_err   = anode_err_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed scans, a symbol table sweep and random
// bus dwells checked against a dwell-level reference model.
module tb_ssd_scan_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  anode_in = 8'hFF;
  logic [6:0]  cathode_in = 7'h7F;
  logic [39:0] digit_codes;
  logic [7:0]  digit_seen;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        decode_err;
  logic        anode_err;

  ssd_scan_decoder dut (
    .clock       (clock),
    .reset       (reset),
    .anode_in    (anode_in),
    .cathode_in  (cathode_in),
    .digit_codes (digit_codes),
    .digit_seen  (digit_seen),
    .frame_valid (frame_valid),
    .frame_count (frame_count),
    .decode_err  (decode_err),
    .anode_err   (anode_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Pulse counters observed on the DUT
  int fv_cnt = 0, de_cnt = 0, ae_cnt = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_valid) fv_cnt++;
      if (decode_err)  de_cnt++;
      if (anode_err)   ae_cnt++;
    end
  end

  // Reference model, updated once per dwell long enough to be sampled
  logic [6:0] pat [20];
  logic [4:0] sym [20];
  logic [4:0] m_codes [8];
  logic [7:0] m_seen;
  int         m_fc, m_fv, m_de, m_ae;

  function automatic logic [4:0] lookup(input logic [6:0] c);
    for (int i = 0; i < 20; i++)
      if (pat[i] == c) return sym[i];
    return 5'h1F;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_codes[k] = 5'h14;
    m_seen = 8'h00;
    m_fc   = 0;
  endtask

  task automatic model_sample(input logic [7:0] an, input logic [6:0] ca);
    int zeros, k;
    logic [4:0] c;
    zeros = 0;
    k = 0;
    for (int i = 0; i < 8; i++)
      if (!an[i]) begin zeros++; k = i; end
    if (zeros == 0) return;
    if (zeros > 1) begin m_ae++; return; end
    c = lookup(ca);
    if (c == 5'h1F) m_de++;
    m_codes[k] = c;
    m_seen[k] = 1'b1;
    if (m_seen == 8'hFF) begin
      m_seen = 8'h00;
      m_fv++;
      m_fc = (m_fc + 1) % 256;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] slot(input int k);
    return digit_codes[5*k +: 5];
  endfunction

  task automatic check_model(input string tag);
    logic [39:0] packed_codes;
    for (int k = 0; k < 8; k++) packed_codes[5*k +: 5] = m_codes[k];
    chk({tag, ".codes"}, 64'(digit_codes), 64'(packed_codes));
    chk({tag, ".seen"},  64'(digit_seen),  64'(m_seen));
    chk({tag, ".fcount"}, 64'(frame_count), 64'(m_fc));
    chk({tag, ".fvalid_pulses"}, 64'(fv_cnt), 64'(m_fv));
    chk({tag, ".decerr_pulses"}, 64'(de_cnt), 64'(m_de));
    chk({tag, ".anerr_pulses"},  64'(ae_cnt), 64'(m_ae));
  endtask

  // Hold one bus pattern for len cycles; 8 or more cycles guarantees a sample
  task automatic dwell(input logic [7:0] an, input logic [6:0] ca, input int len);
    @(negedge clock);
    anode_in   = an;
    cathode_in = ca;
    repeat (len - 1) @(negedge clock);
    if (len >= 8) model_sample(an, ca);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    anode_in   = 8'hFF;
    cathode_in = 7'h7F;
    repeat (3) @(negedge clock);
    model_reset();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  typedef struct {
    logic [7:0] an;
    logic [6:0] ca;
    logic [4:0] exp;
    int         k;
  } vec_t;

  vec_t       vecs [24];
  logic [7:0] scan_an [8];
  logic [6:0] scan_ca [8];

  initial begin
    int found;
    int fv0;
    logic [7:0] pan, ran;
    logic [6:0] pca, rca;
    int rlen, a, b;

    pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
            7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000,
            7'b0111000, 7'b1111001, 7'b1000001, 7'b1110001, 7'b1111111};
    sym = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
            5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h11, 5'h12, 5'h13, 5'h14};
    for (int i = 0; i < 20; i++)
      vecs[i] = '{an: ~(8'h01 << (i % 8)), ca: pat[i], exp: sym[i], k: i % 8};
    vecs[20] = '{an: ~(8'h01 << 4), ca: 7'b1010101, exp: 5'h1F, k: 4};
    vecs[21] = '{an: ~(8'h01 << 5), ca: 7'b0101010, exp: 5'h1F, k: 5};
    vecs[22] = '{an: ~(8'h01 << 6), ca: 7'b1111110, exp: 5'h1F, k: 6};
    vecs[23] = '{an: ~(8'h01 << 7), ca: 7'b0011111, exp: 5'h1F, k: 7};
    scan_an = '{8'b11101111, 8'b11110111, 8'b11111011, 8'b11111101,
                8'b11111110, 8'b01111111, 8'b10111111, 8'b11011111};
    scan_ca = '{7'b0001000, 7'b0100000, 7'b1100000, 7'b0110001,
                7'b0111000, 7'b1111111, 7'b1111111, 7'b1111111};
    m_fv = 0; m_de = 0; m_ae = 0;

    // Reset values while reset is held, then an idle bus
    do_reset();
    chk("rst.codes", 64'(digit_codes), 64'h14_a5_29_4a_52_94 & 64'hFF_FFFF_FFFF);
    chk("rst.seen", 64'(digit_seen), 64'h0);
    chk("rst.fcount", 64'(frame_count), 64'h0);
    chk("rst.pulses", 64'({frame_valid, decode_err, anode_err}), 64'h0);
    release_reset();
    repeat (20) @(negedge clock);
    check_model("idle");

    // Full 8-digit scan, 64 cycles per digit
    fv0 = fv_cnt;
    for (int i = 0; i < 8; i++) dwell(scan_an[i], scan_ca[i], 64);
    chk("scan.slot4", 64'(slot(4)), 64'h0A);
    chk("scan.slot3", 64'(slot(3)), 64'h06);
    chk("scan.slot2", 64'(slot(2)), 64'h0B);
    chk("scan.slot1", 64'(slot(1)), 64'h0C);
    chk("scan.slot0", 64'(slot(0)), 64'h0F);
    chk("scan.slots765", 64'({slot(7), slot(6), slot(5)}), 64'({5'h14, 5'h14, 5'h14}));
    chk("scan.frames", 64'(fv_cnt - fv0), 64'd1);
    chk("scan.fcount", 64'(frame_count), 64'd1);
    chk("scan.seen", 64'(digit_seen), 64'h0);

    // Symbol table sweep
    for (int i = 0; i < 24; i++) begin
      dwell(vecs[i].an, vecs[i].ca, 10);
      chk($sformatf("table[%0d]", i), 64'(slot(vecs[i].k)), 64'(vecs[i].exp));
    end
    check_model("table");

    // Chattering cathode never settles; then exact sample latency
    dwell(8'b11111110, 7'b0110000, 12);
    for (int i = 0; i < 10; i++) dwell(8'b11111110, i[0] ? 7'b1001111 : 7'b0000001, 2);
    chk("chatter.slot0", 64'(slot(0)), 64'h0E);
    @(negedge clock);
    cathode_in = 7'b0000110;
    found = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clock);
      #1;
      if (found == 0 && slot(0) == 5'h03) found = e;
    end
    chk("latency.edges", 64'(found), 64'd6);
    model_sample(8'b11111110, 7'b0000110);
    check_model("latency");

    // Two anodes low, then an unknown cathode pattern
    dwell(8'b11111100, 7'b0000110, 20);
    check_model("anode_err");
    dwell(8'b11111011, 7'b1010101, 20);
    chk("decerr.slot2", 64'(slot(2)), 64'h1F);
    check_model("decode_err");

    // Reset part way through a frame
    do_reset();
    release_reset();
    for (int i = 0; i < 8; i++) dwell(scan_an[i], scan_ca[i], 10);
    for (int i = 0; i < 5; i++) dwell(~(8'h01 << i), pat[i], 10);
    do_reset();
    chk("midrst.seen", 64'(digit_seen), 64'h0);
    chk("midrst.codes", 64'(digit_codes), 64'h14_a5_29_4a_52_94 & 64'hFF_FFFF_FFFF);
    release_reset();
    for (int i = 0; i < 8; i++) dwell(scan_an[i], scan_ca[i], 10);
    chk("midrst.fcount", 64'(frame_count), 64'd1);
    check_model("midrst");

    // 256 frames wrap the frame counter
    do_reset();
    release_reset();
    fv0 = fv_cnt;
    for (int f = 0; f < 256; f++)
      for (int i = 0; i < 8; i++) dwell(~(8'h01 << i), pat[(f + i) % 20], 8);
    chk("wrap.fcount", 64'(frame_count), 64'd0);
    chk("wrap.frames", 64'(fv_cnt - fv0), 64'd256);
    check_model("wrap");

    // Random dwells: short ones must be ignored, long ones sampled
    pan = anode_in;
    pca = cathode_in;
    for (int n = 0; n < 300; n++) begin
      do begin
        a = int'($urandom_range(0, 9));
        if (a == 0) ran = 8'hFF;
        else if (a == 1) begin
          a = int'($urandom_range(0, 7));
          b = (a + 1 + int'($urandom_range(0, 6))) % 8;
          ran = ~((8'h01 << a) | (8'h01 << b));
        end else ran = ~(8'h01 << $urandom_range(0, 7));
        if ($urandom_range(0, 9) < 7) rca = pat[$urandom_range(0, 19)];
        else rca = 7'($urandom);
      end while (ran == pan && rca == pca);
      rlen = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(8, 14));
      dwell(ran, rca, rlen);
      pan = ran;
      pca = rca;
      if (rlen >= 8 && (n % 10) == 9) check_model($sformatf("rand[%0d]", n));
    end
    dwell(8'hFF, 7'h7F, 10);
    check_model("rand.end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
